// File: rtl/image_stream_feeder.sv
// Streams a frame from a synchronous-read BRAM to the window controller as 8-bit pixels,
// paced by line credits, with optional trailing zero lines to flush the bottom windows.
module image_stream_feeder #(
   parameter int unsigned IMG_WIDTH     = 512,
   parameter int unsigned IMG_HEIGHT    = 512,
   parameter int unsigned PRELOAD_LINES = 4,
   parameter int unsigned PAD_LINES     = 0,
   parameter int unsigned ADDR_W        = 18
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_intr,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_data,
   output logic [7:0]        o_pixel_data,
   output logic              o_pixel_data_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
   localparam int unsigned CREDIT_W    = $clog2(TOTAL_LINES + 1);
   localparam int unsigned ROW_W       = CREDIT_W;
   localparam int unsigned COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned PRELOAD_EFF = (PRELOAD_LINES < TOTAL_LINES) ? PRELOAD_LINES : TOTAL_LINES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic                pad_issue;
   logic                p1_valid;
   logic                p1_pad;

   logic line_end_c;
   logic last_line_c;
   logic img_row_c;
   logic next_img_row_c;
   logic credit_inc_c;

   // Line bookkeeping and credit arithmetic for the current issue cycle
   always_comb begin
      line_end_c     = (state == SEND) && (col == COL_W'(IMG_WIDTH - 1));
      last_line_c    = (row == ROW_W'(TOTAL_LINES - 1));
      img_row_c      = (row < ROW_W'(IMG_HEIGHT));
      next_img_row_c = ((row + ROW_W'(1)) < ROW_W'(IMG_HEIGHT));
      credit_inc_c   = i_intr && ((state == SEND) || (state == WAIT));
      credit_nxt     = credit;
      if (credit_inc_c && !line_end_c) begin
         if (credit != '1) credit_nxt = credit + CREDIT_W'(1);
      end else if (line_end_c && !credit_inc_c) begin
         credit_nxt = credit - CREDIT_W'(1);
      end
   end

   // State, issue registers and the two-stage read-to-pixel pipeline
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state              <= IDLE;
         credit             <= '0;
         col                <= '0;
         row                <= '0;
         pad_issue          <= 1'b0;
         p1_valid           <= 1'b0;
         p1_pad             <= 1'b0;
         o_mem_rd_en        <= 1'b0;
         o_mem_addr         <= '0;
         o_pixel_data       <= '0;
         o_pixel_data_valid <= 1'b0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
      end else begin
         p1_valid           <= o_mem_rd_en | pad_issue;
         p1_pad             <= pad_issue;
         o_pixel_data_valid <= p1_valid;
         if (p1_valid) o_pixel_data <= p1_pad ? 8'd0 : i_mem_data;
         credit <= credit_nxt;

         case (state)
            IDLE, DONE: begin
               // o_done follows DONE one cycle late so it lines up with the last drained pixel
               o_done <= (state == DONE) && !i_start;
               if (state == DONE) credit <= '0;
               if (i_start) begin
                  credit     <= CREDIT_W'(PRELOAD_EFF);
                  row        <= '0;
                  col        <= '0;
                  o_mem_addr <= '0;
                  o_busy     <= 1'b1;
                  if (PRELOAD_EFF != 0) begin
                     state       <= SEND;
                     o_mem_rd_en <= 1'b1;
                     pad_issue   <= 1'b0;
                  end else begin
                     state <= WAIT;
                  end
               end
            end

            SEND: begin
               if (img_row_c) o_mem_addr <= o_mem_addr + ADDR_W'(1);
               if (line_end_c) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
                  if (last_line_c) begin
                     state       <= DONE;
                     o_busy      <= 1'b0;
                     o_mem_rd_en <= 1'b0;
                     pad_issue   <= 1'b0;
                     credit      <= '0;
                  end else if (credit_nxt == '0) begin
                     state       <= WAIT;
                     o_mem_rd_en <= 1'b0;
                     pad_issue   <= 1'b0;
                  end else begin
                     o_mem_rd_en <= next_img_row_c;
                     pad_issue   <= !next_img_row_c;
                  end
               end else begin
                  col <= col + COL_W'(1);
               end
            end

            WAIT: begin
               if (credit != '0) begin
                  state       <= SEND;
                  o_mem_rd_en <= img_row_c;
                  pad_issue   <= !img_row_c;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_stream_feeder.sv
// Scoreboard bench for image_stream_feeder: three instances cover preload/credit release,
// zero-line padding, and coincident credit grant/consume.
module tb_image_stream_feeder;

   localparam int unsigned NI    = 3;
   localparam int unsigned W     = 8;
   localparam int unsigned H     = 6;
   localparam int unsigned NPIX  = W * H;
   localparam int unsigned QD    = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n [NI];
   logic       start [NI];
   logic       intr  [NI];
   logic       rd_en [NI];
   logic [7:0] addr  [NI];
   logic [7:0] mem_q [NI];
   logic [7:0] pix   [NI];
   logic       valid [NI];
   logic       busy  [NI];
   logic       done  [NI];

   logic [7:0] exp_pix    [NI][QD];
   bit         exp_done   [NI][QD];
   bit         exp_contig [NI][QD];
   int         wr_ptr [NI] = '{0, 0, 0};
   int         rd_ptr [NI] = '{0, 0, 0};
   int         rd_cnt [NI] = '{0, 0, 0};
   bit         prev_v [NI] = '{0, 0, 0};
   int         tests = 0;
   int         fails = 0;

   image_stream_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(4), .PAD_LINES(0), .ADDR_W(8)) u_a (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .i_intr(intr[0]),
      .o_mem_rd_en(rd_en[0]), .o_mem_addr(addr[0]), .i_mem_data(mem_q[0]),
      .o_pixel_data(pix[0]), .o_pixel_data_valid(valid[0]), .o_busy(busy[0]), .o_done(done[0]));

   image_stream_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(7), .PAD_LINES(1), .ADDR_W(8)) u_b (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .i_intr(intr[1]),
      .o_mem_rd_en(rd_en[1]), .o_mem_addr(addr[1]), .i_mem_data(mem_q[1]),
      .o_pixel_data(pix[1]), .o_pixel_data_valid(valid[1]), .o_busy(busy[1]), .o_done(done[1]));

   image_stream_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(1), .PAD_LINES(0), .ADDR_W(8)) u_c (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_start(start[2]), .i_intr(intr[2]),
      .o_mem_rd_en(rd_en[2]), .o_mem_addr(addr[2]), .i_mem_data(mem_q[2]),
      .o_pixel_data(pix[2]), .o_pixel_data_valid(valid[2]), .o_busy(busy[2]), .o_done(done[2]));

   // Frame memory model: memory[k] = k, one-cycle read latency
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) if (rd_en[i]) mem_q[i] <= addr[i];
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int i, input int data, input bit contig, input bit last);
      exp_pix[i][wr_ptr[i] % QD]    = 8'(data);
      exp_contig[i][wr_ptr[i] % QD] = contig;
      exp_done[i][wr_ptr[i] % QD]   = last;
      wr_ptr[i]++;
   endtask

   task automatic push_range(input int i, input int lo, input int hi, input bit last_done);
      for (int k = lo; k <= hi; k++) push(i, k, (k != lo), last_done && (k == hi));
   endtask

   // Monitor: checks read addresses in order and pops expected pixels whenever valid
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
               rd_cnt[i] = 0;
               prev_v[i] = 1'b0;
            end else begin
               if (rd_en[i]) begin
                  check($sformatf("rd_addr[%0d]", i), int'(addr[i]), rd_cnt[i] % NPIX);
                  rd_cnt[i]++;
               end
               if (valid[i]) begin
                  if (rd_ptr[i] == wr_ptr[i]) begin
                     tests++;
                     fails++;
                     $display("FAIL spurious_pixel[%0d]: got data %0d with no pixel expected", i, pix[i]);
                  end else begin
                     check($sformatf("pixel[%0d]#%0d", i, rd_ptr[i]), int'(pix[i]),
                           int'(exp_pix[i][rd_ptr[i] % QD]));
                     check($sformatf("done_at_pixel[%0d]#%0d", i, rd_ptr[i]), int'(done[i]),
                           int'(exp_done[i][rd_ptr[i] % QD]));
                     if (exp_contig[i][rd_ptr[i] % QD])
                        check($sformatf("no_bubble[%0d]#%0d", i, rd_ptr[i]), int'(prev_v[i]), 1);
                     rd_ptr[i]++;
                  end
               end
               prev_v[i] = valid[i];
            end
         end
      end
   end

   task automatic start_frame(input int i, input bit chk_latency);
      int n;
      @(negedge clk) start[i] = 1'b1;
      @(negedge clk) start[i] = 1'b0;
      if (chk_latency) begin
         n = 0;
         while (!rd_en[i] && n < 10) begin @(negedge clk); n++; end
         check($sformatf("first_read_seen[%0d]", i), int'(rd_en[i]), 1);
         n = 0;
         while (!valid[i] && n < 10) begin @(negedge clk); n++; end
         check($sformatf("first_pixel_latency[%0d]", i), n, 2);
      end
   endtask

   task automatic wait_drain(input int i, input int budget);
      int n = 0;
      while (rd_ptr[i] != wr_ptr[i] && n < budget) begin @(negedge clk); n++; end
      if (rd_ptr[i] != wr_ptr[i]) check($sformatf("drain_timeout[%0d]", i), rd_ptr[i], wr_ptr[i]);
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_intr(input int i);
      @(negedge clk) intr[i] = 1'b1;
      @(negedge clk) intr[i] = 1'b0;
   endtask

   task automatic idle_check(input int i, input int cycles, input string name);
      int c0 = rd_cnt[i];
      repeat (cycles) @(negedge clk);
      check(name, rd_cnt[i], c0);
   endtask

   task automatic run_frame_a(input int exp_reads);
      push_range(0, 0, 31, 1'b0);
      start_frame(0, 1'b1);
      wait_drain(0, 200);
      idle_check(0, 20, "a_wait_no_reads");
      check("a_busy_in_wait", int'(busy[0]), 1);
      check("a_done_in_wait", int'(done[0]), 0);
      push_range(0, 32, 39, 1'b0);
      pulse_intr(0);
      repeat (18) @(negedge clk);
      push_range(0, 40, 47, 1'b1);
      pulse_intr(0);
      wait_drain(0, 200);
      check("a_reads_total", rd_cnt[0], exp_reads);
      check("a_done_level", int'(done[0]), 1);
      check("a_busy_after_done", int'(busy[0]), 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < NI; i++) begin
         rst_n[i] = 1'b0;
         start[i] = 1'b0;
         intr[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_rd_en[%0d]", i), int'(rd_en[i]), 0);
         check($sformatf("rst_valid[%0d]", i), int'(valid[i]), 0);
         check($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
         check($sformatf("rst_done[%0d]", i), int'(done[i]), 0);
         check($sformatf("rst_addr[%0d]", i), int'(addr[i]), 0);
         check($sformatf("rst_pix[%0d]", i), int'(pix[i]), 0);
      end
      for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
      repeat (2) @(negedge clk);

      // Preload then credit release, then intr in DONE, then restart from DONE
      run_frame_a(48);
      pulse_intr(0);
      idle_check(0, 10, "a_done_intr_ignored");
      check("a_done_holds", int'(done[0]), 1);
      run_frame_a(96);

      // Asynchronous reset at col 3 of line 1, then restart from address 0
      push_range(0, 0, 31, 1'b0);
      start_frame(0, 1'b0);
      n = 0;
      while (!(rd_en[0] && addr[0] == 8'd11) && n < 50) begin @(negedge clk); n++; end
      check("a_reach_line1_col3", int'(addr[0]), 11);
      #2 rst_n[0] = 1'b0;
      #1;
      check("a_async_rst_valid", int'(valid[0]), 0);
      check("a_async_rst_rd_en", int'(rd_en[0]), 0);
      check("a_async_rst_busy", int'(busy[0]), 0);
      check("a_async_rst_done", int'(done[0]), 0);
      wr_ptr[0] = rd_ptr[0];
      @(negedge clk);
      @(negedge clk) rst_n[0] = 1'b1;
      push_range(0, 0, 31, 1'b0);
      start_frame(0, 1'b1);
      wait_drain(0, 200);
      check("a_reads_after_reset", rd_cnt[0], 32);

      // Padding: 48 image pixels then 8 zeros, start during SEND ignored
      push_range(1, 0, 47, 1'b0);
      for (int k = 0; k < 8; k++) push(1, 0, 1'b1, k == 7);
      start_frame(1, 1'b1);
      repeat (8) @(negedge clk);
      @(negedge clk) start[1] = 1'b1;
      @(negedge clk) start[1] = 1'b0;
      wait_drain(1, 300);
      check("b_reads_total", rd_cnt[1], 48);
      check("b_done_level", int'(done[1]), 1);
      check("b_busy_after_done", int'(busy[1]), 0);

      // Credit grant coincident with the line-0 end: line 1 follows without a gap
      push_range(2, 0, 15, 1'b0);
      start_frame(2, 1'b0);
      n = 0;
      while (!(rd_en[2] && addr[2] == 8'd7) && n < 50) begin @(negedge clk); n++; end
      check("c_reach_line0_end", int'(addr[2]), 7);
      intr[2] = 1'b1;
      @(negedge clk) intr[2] = 1'b0;
      wait_drain(2, 200);
      idle_check(2, 20, "c_credit_zero_no_reads");
      check("c_reads_two_lines", rd_cnt[2], 16);
      check("c_busy_in_wait", int'(busy[2]), 1);
      push_range(2, 16, 23, 1'b0);
      pulse_intr(2);
      wait_drain(2, 200);
      idle_check(2, 20, "c_one_line_per_intr");
      check("c_reads_three_lines", rd_cnt[2], 24);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/image_stream_feeder.md
Name: image_stream_feeder

Overview:
- Frame-memory reader that streams 8-bit pixels into the line-buffer window controller.
- Paces output by line credits:
  - preloads PRELOAD_LINES lines, then releases one further line for each i_intr pulse (one line consumed downstream);
  - appends PAD_LINES zero lines to flush the bottom windows.
- Sits between the frame BRAM (synchronous read, 1-cycle latency) and the window controller's pixel input.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, image lines read from memory.
- PRELOAD_LINES, 4, initial line credit granted on start.
- PAD_LINES, 0, zero-valued lines emitted after the last image line.
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start-frame pulse; honoured only in IDLE or DONE.
- i_intr  in  1  one-cycle pulse from the window controller: one line consumed, grants one line credit.
- o_mem_rd_en  out  1  memory read strobe.
- o_mem_addr  out  ADDR_W  memory read address.
- i_mem_data  in  8  memory read data, valid the cycle after o_mem_rd_en.
- o_pixel_data  out  8  pixel to the window controller.
- o_pixel_data_valid  out  1  pixel qualifier.
- o_busy  out  1  high in any state other than IDLE and DONE.
- o_done  out  1  level, high in DONE.

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE; credit=0; addr=0; col=0; row=0.
  - All outputs 0.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - i_start -> credit=min(PRELOAD_LINES, IMG_HEIGHT+PAD_LINES); addr=0; row=0; col=0; go to SEND.
- SEND:
  - One pixel per cycle, no bubbles within a line.
  - Image row (row<IMG_HEIGHT): o_mem_rd_en=1, o_mem_addr=addr; addr increments every cycle.
  - Pad row: no memory read; a zero pixel is scheduled instead.
  - col wraps IMG_WIDTH-1 -> 0; the line-end cycle consumes 1 credit and row++.
  - At a line end:
    - if row+1 == IMG_HEIGHT+PAD_LINES -> DONE;
    - else if resulting credit==0 -> WAIT;
    - else stay in SEND with no gap between lines.
- WAIT:
  - No reads issued.
  - credit>0 (i.e. i_intr arrived) -> SEND next cycle.
- DONE:
  - o_done=1; further i_intr ignored, credit forced to 0.
  - i_start -> restart exactly as from IDLE.
- Credit arithmetic:
  - i_intr adds 1 in any state except IDLE/DONE.
  - i_intr on the same cycle as a line-end consume: net 0.
  - Saturates at 2^CREDIT_W-1, with CREDIT_W = clog2(IMG_HEIGHT+PAD_LINES+1).
- Latency:
  - Read issued at cycle N -> i_mem_data at N+1 -> registered onto o_pixel_data with o_pixel_data_valid=1 at N+2.
  - Pad pixels use the same 2-cycle pipeline with data 0, so ordering is preserved.
  - The pipeline drains after leaving SEND: the last pixel appears 2 cycles after the last issue. o_done rises on the cycle that last pixel is presented.
- o_pixel_data holds its last value when valid=0; the value is don't-care for checking.
- i_start while in SEND or WAIT: ignored.
- Reset mid-frame: outputs drop to 0 immediately; in-flight pipeline contents are discarded.
- Total valid pixels per frame: exactly IMG_WIDTH*(IMG_HEIGHT+PAD_LINES). Addresses run 0..IMG_WIDTH*IMG_HEIGHT-1 in order, with no repeats.

Test Plan:
- Preload:
  - Setup: IMG_WIDTH=8, IMG_HEIGHT=6, PRELOAD=4, PAD=0, memory[k]=k; pulse i_start, never pulse i_intr.
  - Required: exactly 32 valid pixels with data 0..31 contiguous; first valid 2 cycles after the first o_mem_rd_en; then WAIT, o_busy=1.
- Credit release:
  - Stimulus: after the preload case, pulse i_intr twice, 20 cycles apart.
  - Required: pixels 32..39, then 40..47; o_done=1 on the cycle pixel 47 is presented; total 48.
- Padding:
  - Setup: PAD_LINES=1, PRELOAD=7.
  - Required: 48 image pixels followed by 8 valid zeros back-to-back; o_mem_rd_en never asserted during the pad line.
- Simultaneous events:
  - Setup: PRELOAD=1, with i_intr asserted on the line-end cycle of line 0.
  - Required: line 1 follows line 0 with no gap, and credit stays 0 thereafter.
- Reset mid-line:
  - Stimulus: deassert i_rst_n at col 3 of line 1.
  - Required: o_pixel_data_valid, o_mem_rd_en, o_busy and o_done all 0 asynchronously. A new i_start restarts at address 0.
- Restart and ignored start:
  - Stimulus: i_start during SEND.
  - Required: no effect.
  - Stimulus: i_start in DONE.
  - Required: a full second frame identical to the first.
